async_fifo_read_adapter: RTL

ASYNC_FIFO_READ_ADAPTER -- requirements
Module: async_fifo_read_adapter

---
 rtl/async_fifo_read_adapter.sv | 80 ++++++++
 1 files changed

// File: rtl/async_fifo_read_adapter.sv
`default_nettype none
// ============================================================================
// async_fifo_read_adapter: turns an async_fifo empty/read_en read port into a
// valid/ready stream through a 2-entry skid buffer.   Revision: 1.0
// ============================================================================
module async_fifo_read_adapter #(
  parameter int BITS       = 32,
  parameter int COUNT_BITS = 16
) (
  input  logic                  read_clk,
  input  logic                  read_rst,
  input  logic                  p_read_empty,
  output logic                  p_read_en,
  input  logic [BITS-1:0]       p_read_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [BITS-1:0]       m_data,
  output logic [COUNT_BITS-1:0] m_count
);

  logic [1:0]            r_occ;
  logic                  r_infl;
  logic [BITS-1:0]       r_head;
  logic [BITS-1:0]       r_tail;
  logic [COUNT_BITS-1:0] r_count;

  logic                  w_pop;
  logic [2:0]            w_level;
  logic [1:0]            w_occ_after_pop;
  logic [1:0]            w_occ_next;
  logic [BITS-1:0]       w_head_next;
  logic [BITS-1:0]       w_tail_next;

  assign m_valid = (r_occ != 2'd0);
  assign m_data  = r_head;
  assign m_count = r_count;
  assign w_pop   = m_valid & m_ready;

  // Words already owed to the buffer (stored + in flight), less the one leaving now.
  assign w_level   = {1'b0, r_occ} + {2'b00, r_infl} - {2'b00, w_pop};
  assign p_read_en = ~p_read_empty & ~read_rst & (w_level < 3'd2);

  always_comb begin
    w_occ_after_pop = r_occ - {1'b0, w_pop};
    w_head_next     = r_head;
    w_tail_next     = r_tail;
    if (w_pop) begin
      w_head_next = r_tail;
    end
    // A landing word goes behind whatever remains after this cycle's pop.
    if (r_infl) begin
      if (w_occ_after_pop == 2'd0) begin
        w_head_next = p_read_data;
      end else begin
        w_tail_next = p_read_data;
      end
    end
    w_occ_next = w_occ_after_pop + {1'b0, r_infl};
  end

  always_ff @(posedge read_clk or posedge read_rst) begin
    if (read_rst) begin
      r_occ   <= 2'd0;
      r_infl  <= 1'b0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_occ  <= w_occ_next;
      r_infl <= p_read_en;
      r_head <= w_head_next;
      r_tail <= w_tail_next;
      if (w_pop) begin
        r_count <= r_count + COUNT_BITS'(1);
      end
    end
  end

endmodule
`default_nettype wire
